// File: rtl/filter_window.sv
// filter_window: two-dimensional active-window generator for the VESA pixel path.
// Counts pixels/lines from sync edges and flags pixels inside a frame-shadowed rectangle.
module filter_window #(
  parameter int    X_CNT_WIDTH = 12,
  parameter int    Y_CNT_WIDTH = 12,
  parameter string HS_POLARITY = "NEGATIVE",
  parameter string VS_POLARITY = "NEGATIVE",
  parameter int    X_START     = 259,
  parameter int    X_END       = 899,
  parameter int    Y_START     = 0,
  parameter int    Y_END       = 720
) (
  input  logic                   i_pclk,
  input  logic                   i_arst,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [X_CNT_WIDTH-1:0] i_x_start,
  input  logic [X_CNT_WIDTH-1:0] i_x_end,
  input  logic [Y_CNT_WIDTH-1:0] i_y_start,
  input  logic [Y_CNT_WIDTH-1:0] i_y_end,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_x_en,
  output logic                   o_y_en,
  output logic                   o_en,
  output logic                   o_line_start,
  output logic                   o_frame_start
);

  localparam logic HS_ACT = (HS_POLARITY == "POSITIVE") ? 1'b1 : 1'b0;
  localparam logic VS_ACT = (VS_POLARITY == "POSITIVE") ? 1'b1 : 1'b0;

  localparam logic [X_CNT_WIDTH-1:0] XS_RST = X_CNT_WIDTH'(X_START);
  localparam logic [X_CNT_WIDTH-1:0] XE_RST = X_CNT_WIDTH'(X_END);
  localparam logic [Y_CNT_WIDTH-1:0] YS_RST = Y_CNT_WIDTH'(Y_START);
  localparam logic [Y_CNT_WIDTH-1:0] YE_RST = Y_CNT_WIDTH'(Y_END);
  localparam logic [X_CNT_WIDTH-1:0] X_MAX  = '1;
  localparam logic [Y_CNT_WIDTH-1:0] Y_MAX  = '1;

  logic                   r_hs_d1;
  logic                   r_vs_d1;
  logic                   r_hs_armed;
  logic                   r_vs_armed;
  logic                   r_hs_edge_d;
  logic                   r_vs_edge_d;
  logic [X_CNT_WIDTH-1:0] r_x_cnt;
  logic [Y_CNT_WIDTH-1:0] r_y_cnt;
  logic [X_CNT_WIDTH-1:0] r_xs;
  logic [X_CNT_WIDTH-1:0] r_xe;
  logic [Y_CNT_WIDTH-1:0] r_ys;
  logic [Y_CNT_WIDTH-1:0] r_ye;

  logic                   w_hs_act;
  logic                   w_vs_act;
  logic                   w_hs_edge;
  logic                   w_vs_edge;
  logic [X_CNT_WIDTH-1:0] w_x_inc;
  logic [Y_CNT_WIDTH-1:0] w_y_inc;
  logic                   w_x_in;
  logic                   w_y_in;

  // The armed flags require an inactive sample after reset, so a sync that is
  // already active when reset releases cannot fake an edge.
  assign w_hs_act  = (i_hsync == HS_ACT);
  assign w_vs_act  = (i_vsync == VS_ACT);
  assign w_hs_edge = w_hs_act && (r_hs_d1 != HS_ACT) && r_hs_armed;
  assign w_vs_edge = w_vs_act && (r_vs_d1 != VS_ACT) && r_vs_armed;

  assign w_x_inc = (r_x_cnt == X_MAX) ? r_x_cnt : r_x_cnt + X_CNT_WIDTH'(1);
  assign w_y_inc = (r_y_cnt == Y_MAX) ? r_y_cnt : r_y_cnt + Y_CNT_WIDTH'(1);

  assign w_x_in = (r_x_cnt >= r_xs) && (r_x_cnt < r_xe);
  assign w_y_in = (r_y_cnt >= r_ys) && (r_y_cnt < r_ye);

  always_ff @(posedge i_pclk) begin
    if (i_arst) begin
      r_hs_d1       <= ~HS_ACT;
      r_vs_d1       <= ~VS_ACT;
      o_hsync       <= ~HS_ACT;
      o_vsync       <= ~VS_ACT;
      r_hs_armed    <= 1'b0;
      r_vs_armed    <= 1'b0;
      r_hs_edge_d   <= 1'b0;
      r_vs_edge_d   <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      r_hs_d1       <= i_hsync;
      r_vs_d1       <= i_vsync;
      o_hsync       <= r_hs_d1;
      o_vsync       <= r_vs_d1;
      r_hs_armed    <= r_hs_armed | ~w_hs_act;
      r_vs_armed    <= r_vs_armed | ~w_vs_act;
      r_hs_edge_d   <= w_hs_edge;
      r_vs_edge_d   <= w_vs_edge;
      o_line_start  <= r_hs_edge_d;
      o_frame_start <= r_vs_edge_d;
    end
  end

  // vsync takes priority over hsync for the line counter; bounds only move on vsync.
  always_ff @(posedge i_pclk) begin
    if (i_arst) begin
      r_x_cnt <= X_MAX;
      r_y_cnt <= Y_MAX;
      r_xs    <= XS_RST;
      r_xe    <= XE_RST;
      r_ys    <= YS_RST;
      r_ye    <= YE_RST;
    end else begin
      if (w_hs_edge) begin
        r_x_cnt <= '0;
      end else begin
        r_x_cnt <= w_x_inc;
      end
      if (w_vs_edge) begin
        r_y_cnt <= '0;
        r_xs    <= i_x_start;
        r_xe    <= i_x_end;
        r_ys    <= i_y_start;
        r_ye    <= i_y_end;
      end else if (w_hs_edge) begin
        r_y_cnt <= w_y_inc;
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_arst) begin
      o_x_en <= 1'b0;
      o_y_en <= 1'b0;
      o_en   <= 1'b0;
    end else begin
      o_x_en <= w_x_in;
      o_y_en <= w_y_in;
      o_en   <= w_x_in & w_y_in;
    end
  end

endmodule

// File: tb/tb_filter_window.sv
// tb_filter_window: drives NEGATIVE and POSITIVE builds with the same logical syncs and
// checks both every cycle against an index-based model, plus frame-level tables.
module tb_filter_window;

  localparam int HIST = 32768;

  typedef struct {
    logic hs;
    logic vs;
    logic xEn;
    logic yEn;
    logic en;
    logic ls;
    logic fs;
  } outs_t;

  typedef struct {
    int xs;
    int xe;
    int ys;
    int ye;
    int nLines;
    int lineLen;
    int expX;
    int expY;
    int expEn;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        hsA = 1'b0;
  logic        vsA = 1'b0;
  logic [11:0] xsD = 12'd259;
  logic [11:0] xeD = 12'd899;
  logic [11:0] ysD = 12'd0;
  logic [11:0] yeD = 12'd720;
  int nxtXs = 259, nxtXe = 899, nxtYs = 0, nxtYe = 720;

  logic negHs, negVs, negXEn, negYEn, negEn, negLs, negFs;
  logic posHs, posVs, posXEn, posYEn, posEn, posLs, posFs;

  filter_window #(
    .X_CNT_WIDTH(12), .Y_CNT_WIDTH(12), .HS_POLARITY("NEGATIVE"), .VS_POLARITY("NEGATIVE")
  ) dutNeg (
    .i_pclk(clk), .i_arst(rst), .i_hsync(~hsA), .i_vsync(~vsA),
    .i_x_start(xsD), .i_x_end(xeD), .i_y_start(ysD), .i_y_end(yeD),
    .o_hsync(negHs), .o_vsync(negVs), .o_x_en(negXEn), .o_y_en(negYEn), .o_en(negEn),
    .o_line_start(negLs), .o_frame_start(negFs)
  );

  filter_window #(
    .X_CNT_WIDTH(12), .Y_CNT_WIDTH(12), .HS_POLARITY("POSITIVE"), .VS_POLARITY("POSITIVE")
  ) dutPos (
    .i_pclk(clk), .i_arst(rst), .i_hsync(hsA), .i_vsync(vsA),
    .i_x_start(xsD), .i_x_end(xeD), .i_y_start(ysD), .i_y_end(yeD),
    .o_hsync(posHs), .o_vsync(posVs), .o_x_en(posXEn), .o_y_en(posYEn), .o_en(posEn),
    .o_line_start(posLs), .o_frame_start(posFs)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int checkFrom = 1 << 30;
  outs_t expQ [4];
  outs_t histNeg [HIST];
  outs_t histPos [HIST];
  int cntX [2], cntY [2], cntEn [2], cntLs [2];
  int sX [2], sY [2], sEn [2], sLs [2];

  // Model: pixel index = cycles since last hsync edge, line = hsync edges since vsync edge.
  int   mLastHs = -1000000;
  int   mLine = 1000000;
  logic mHsPrev = 1'b1;
  logic mVsPrev = 1'b1;
  int   mXs = 259, mXe = 899, mYs = 0, mYe = 720;

  task automatic checkBit(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, req);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  task automatic cmpOuts(input string tag, input outs_t a, input outs_t e);
    checkBit({tag, ".hsync"}, a.hs, e.hs);
    checkBit({tag, ".vsync"}, a.vs, e.vs);
    checkBit({tag, ".x_en"}, a.xEn, e.xEn);
    checkBit({tag, ".y_en"}, a.yEn, e.yEn);
    checkBit({tag, ".en"}, a.en, e.en);
    checkBit({tag, ".line_start"}, a.ls, e.ls);
    checkBit({tag, ".frame_start"}, a.fs, e.fs);
  endtask

  function automatic outs_t predict(input logic h, input logic v, input logic he, input logic ve);
    outs_t r;
    int k;
    int ln;
    logic xi;
    logic yi;
    k  = cyc - mLastHs;
    if (k > 4095) k = 4095;
    ln = (mLine > 4095) ? 4095 : mLine;
    xi = (k >= mXs) && (k < mXe);
    yi = (ln >= mYs) && (ln < mYe);
    r.hs = h; r.vs = v; r.xEn = xi; r.yEn = yi; r.en = xi & yi; r.ls = he; r.fs = ve;
    return r;
  endfunction

  task automatic modelStep();
    logic hsEdge;
    logic vsEdge;
    if (rst) begin
      mLastHs = -1000000; mLine = 1000000; mHsPrev = 1'b1; mVsPrev = 1'b1;
      mXs = 259; mXe = 899; mYs = 0; mYe = 720;
      if (checkFrom > cyc + 1) checkFrom = cyc + 1;
      expQ[(cyc + 1) % 4] = '{default: 1'b0};
      expQ[(cyc + 2) % 4] = predict(1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      hsEdge = hsA && !mHsPrev;
      vsEdge = vsA && !mVsPrev;
      mHsPrev = hsA;
      mVsPrev = vsA;
      if (vsEdge) begin
        mXs = int'(xsD); mXe = int'(xeD); mYs = int'(ysD); mYe = int'(yeD);
        mLine = 0;
      end else if (hsEdge) begin
        mLine++;
      end
      if (hsEdge) mLastHs = cyc;
      expQ[(cyc + 2) % 4] = predict(hsA, vsA, hsEdge, vsEdge);
    end
  endtask

  task automatic checkOutput();
    outs_t n;
    outs_t p;
    n = '{hs: ~negHs, vs: ~negVs, xEn: negXEn, yEn: negYEn, en: negEn, ls: negLs, fs: negFs};
    p = '{hs: posHs, vs: posVs, xEn: posXEn, yEn: posYEn, en: posEn, ls: posLs, fs: posFs};
    if (cyc < HIST) begin
      histNeg[cyc] = n;
      histPos[cyc] = p;
    end
    cntX[0] += (n.xEn === 1'b1) ? 1 : 0;  cntX[1] += (p.xEn === 1'b1) ? 1 : 0;
    cntY[0] += (n.yEn === 1'b1) ? 1 : 0;  cntY[1] += (p.yEn === 1'b1) ? 1 : 0;
    cntEn[0] += (n.en === 1'b1) ? 1 : 0;  cntEn[1] += (p.en === 1'b1) ? 1 : 0;
    cntLs[0] += (n.ls === 1'b1) ? 1 : 0;  cntLs[1] += (p.ls === 1'b1) ? 1 : 0;
    if (cyc >= checkFrom) begin
      cmpOuts("neg", n, expQ[cyc % 4]);
      cmpOuts("pos", p, expQ[cyc % 4]);
    end
  endtask

  // One cycle: look at this cycle's outputs, then drive this cycle's inputs.
  task automatic applyStimulus(input logic r, input logic h, input logic v);
    @(negedge clk);
    checkOutput();
    rst = r;
    hsA = h;
    vsA = v;
    xsD = 12'(nxtXs); xeD = 12'(nxtXe); ysD = 12'(nxtYs); yeD = 12'(nxtYe);
    modelStep();
    cyc++;
  endtask

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      sX[i] = cntX[i]; sY[i] = cntY[i]; sEn[i] = cntEn[i]; sLs[i] = cntLs[i];
    end
  endtask

  task automatic setBounds(input int xs, input int xe, input int ys, input int ye);
    nxtXs = xs; nxtXe = xe; nxtYs = ys; nxtYe = ye;
  endtask

  task automatic vsPulse();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic driveLine(input int len, output int t);
    t = cyc;
    for (int p = 0; p < len; p++) applyStimulus(1'b0, p < 2, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic runFrame(input int nLines, input int lineLen, input int midXs);
    int t;
    vsPulse();
    for (int l = 0; l < nLines; l++) begin
      driveLine(lineLen, t);
      if (l == 0 && midXs >= 0) nxtXs = midXs;
    end
    idle(4);
  endtask

  initial begin
    vec_t tbl [6];
    int t;
    int r;
    logic nh, nv;

    tbl[0] = '{4, 8, 1, 3, 4, 16, 16, 32, 8};
    tbl[1] = '{0, 16, 1, 4, 4, 16, 64, 48, 48};
    tbl[2] = '{5, 5, 1, 3, 4, 16, 0, 32, 0};
    tbl[3] = '{10, 3, 2, 1, 4, 16, 0, 0, 0};
    tbl[4] = '{0, 1, 3, 4, 5, 12, 5, 12, 1};
    tbl[5] = '{11, 12, 1, 5, 5, 12, 5, 48, 4};
    for (int i = 0; i < 2; i++) begin
      cntX[i] = 0; cntY[i] = 0; cntEn[i] = 0; cntLs[i] = 0;
    end

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    idle(3);

    $display("[TB] frame table");
    for (int i = 0; i < 6; i++) begin
      setBounds(tbl[i].xs, tbl[i].xe, tbl[i].ys, tbl[i].ye);
      snap();
      runFrame(tbl[i].nLines, tbl[i].lineLen, -1);
      for (int d = 0; d < 2; d++) begin
        checkVal($sformatf("tbl%0d.d%0d.xcount", i, d), cntX[d] - sX[d], tbl[i].expX);
        checkVal($sformatf("tbl%0d.d%0d.ycount", i, d), cntY[d] - sY[d], tbl[i].expY);
        checkVal($sformatf("tbl%0d.d%0d.encount", i, d), cntEn[d] - sEn[d], tbl[i].expEn);
      end
    end

    $display("[TB] mid-frame bound change");
    setBounds(4, 8, 1, 3);
    snap();
    runFrame(4, 16, 2);
    checkVal("mid.xcount", cntX[0] - sX[0], 16);
    checkVal("mid.encount", cntEn[0] - sEn[0], 8);
    vsPulse();
    driveLine(16, t);
    idle(3);
    checkBit("mid.next.t+3", histNeg[t + 3].xEn, 1'b0);
    checkBit("mid.next.t+4", histNeg[t + 4].xEn, 1'b1);
    checkBit("mid.next.pos.t+4", histPos[t + 4].xEn, 1'b1);

    $display("[TB] long line saturation");
    setBounds(4000, 4095, 1, 3);
    vsPulse();
    snap();
    driveLine(5000, t);
    idle(4);
    checkVal("sat.xcount", cntX[0] - sX[0], 95);
    checkVal("sat.pos.xcount", cntX[1] - sX[1], 95);
    checkVal("sat.encount", cntEn[0] - sEn[0], 95);
    checkBit("sat.k3999", histNeg[t + 2 + 3999].xEn, 1'b0);
    checkBit("sat.k4000", histNeg[t + 2 + 4000].xEn, 1'b1);
    checkBit("sat.k4094", histNeg[t + 2 + 4094].xEn, 1'b1);
    checkBit("sat.k4095", histNeg[t + 2 + 4095].xEn, 1'b0);
    checkBit("sat.k4999", histNeg[t + 2 + 4999].xEn, 1'b0);

    $display("[TB] simultaneous edges");
    setBounds(0, 1, 0, 1);
    idle(1);
    t = cyc;
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    idle(4);
    checkBit("sim.t+1.ls", histNeg[t + 1].ls, 1'b0);
    checkBit("sim.t+2.ls", histNeg[t + 2].ls, 1'b1);
    checkBit("sim.t+2.fs", histNeg[t + 2].fs, 1'b1);
    checkBit("sim.t+2.en", histNeg[t + 2].en, 1'b1);
    checkBit("sim.t+3.xen", histNeg[t + 3].xEn, 1'b0);
    checkBit("sim.pos.t+2.en", histPos[t + 2].en, 1'b1);

    $display("[TB] reset mid-window");
    setBounds(0, 16, 1, 4);
    vsPulse();
    t = cyc;
    for (int p = 0; p < 8; p++) applyStimulus(1'b0, p < 2, 1'b0);
    r = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    snap();
    for (int l = 0; l < 3; l++) driveLine(16, t);
    idle(4);
    checkBit("rst.before.en", histNeg[r].en, 1'b1);
    checkBit("rst.after.xen", histNeg[r + 1].xEn, 1'b0);
    checkBit("rst.after.yen", histNeg[r + 1].yEn, 1'b0);
    checkBit("rst.after.en", histNeg[r + 1].en, 1'b0);
    checkBit("rst.pos.after.en", histPos[r + 1].en, 1'b0);
    checkVal("rst.encount", cntEn[0] - sEn[0], 0);
    checkVal("rst.pos.encount", cntEn[1] - sEn[1], 0);

    $display("[TB] sync active across reset");
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    snap();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    idle(1);
    checkVal("held.lscount", cntLs[0] - sLs[0], 0);
    checkVal("held.pos.lscount", cntLs[1] - sLs[1], 0);
    t = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle(3);
    checkBit("held.newedge.ls", histNeg[t + 2].ls, 1'b1);

    $display("[TB] random");
    nh = 1'b0;
    nv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) nh = ~nh;
      if ($urandom_range(0, 59) == 0) nv = ~nv;
      if ($urandom_range(0, 19) == 0)
        setBounds($urandom_range(0, 30), $urandom_range(0, 30),
                  $urandom_range(0, 8), $urandom_range(0, 8));
      applyStimulus($urandom_range(0, 299) == 0, nh, nv);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
